// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus bundle: the memory read port (Address/Data/strobes)
// and the decode-side valid/ready handshake (instr/instrPC/instrValid/instrReady).
interface instruction_fetch_if;
    logic [31:0] Address;
    logic [31:0] Data;
    logic        CS;
    logic        OE;
    logic        WE;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic        instrValid;
    logic        instrReady;

    // Fetch unit side: drives memory address/strobes and the decode entry
    modport master (
        output Address, CS, OE, WE, instr, instrPC, instrValid,
        input  Data, instrReady
    );

    // Memory/decode side
    modport slave (
        input  Address, CS, OE, WE, instr, instrPC, instrValid,
        output Data, instrReady
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit. Walks the PC through instruction memory once the
// loader raises start, reads each word with a fixed strobe-hold latency and
// queues {word, pc} for decode. A taken branch empties the queue, abandons
// any in-flight read and restarts fetch at the target.
// Configuration macro: IF_PREFETCH_EN (defined: 2-entry queue so the next read
// overlaps the held entry; undefined: 1-entry queue).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       branchTaken,
    input  logic [31:0]                branchTarget,
    instruction_fetch_if.master        bus
);
`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [3:0]  LAT_LOAD = 4'(MEM_LATENCY - 1);
    localparam logic [1:0]  DEPTH_C  = 2'(DEPTH);
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] addr;
    logic        cs, oe;
    logic [3:0]  lat_cnt;
    logic [1:0]  count, count_nxt;
    logic [1:0]  wr_idx;
    logic [31:0] fifo_word     [DEPTH];
    logic [31:0] fifo_pc       [DEPTH];
    logic [31:0] fifo_word_nxt [DEPTH];
    logic [31:0] fifo_pc_nxt   [DEPTH];
    logic        push, pop, flush, reload;

    assign pop    = (count != 2'd0) && bus.instrReady;
    assign flush  = branchTaken && (state != IDLE);
    assign wr_idx = count - {1'b0, pop};

    assign bus.Address    = addr;
    assign bus.CS         = cs;
    assign bus.OE         = oe;
    assign bus.WE         = 1'b1;
    assign bus.instr      = fifo_word[0];
    assign bus.instrPC    = fifo_pc[0];
    assign bus.instrValid = (count != 2'd0);

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state, PC update, capture and counter-reload decisions
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        reload    = 1'b0;
        if (flush) begin
            // Redirect wins over any capture landing on this same edge
            state_nxt = FETCH;
            pc_nxt    = {branchTarget[31:2], 2'b00};
            reload    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = FETCH;
                        pc_nxt    = START_PC;
                        reload    = 1'b1;
                    end
                end
                FETCH: begin
                    if (lat_cnt == 4'd0) begin
                        push   = 1'b1;
                        pc_nxt = pc + 32'd4;
                        // Issue again only if the queue still has room after this edge
                        if ((count + 2'd1 - {1'b0, pop}) < DEPTH_C) reload = 1'b1;
                        else                                        state_nxt = STALL;
                    end
                end
                STALL: begin
                    if ((count - {1'b0, pop}) < DEPTH_C) begin
                        state_nxt = FETCH;
                        reload    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // PC, registered memory address/strobes and read-latency counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc      <= START_PC;
            addr    <= 32'd0;
            cs      <= 1'b1;
            oe      <= 1'b1;
            lat_cnt <= 4'd0;
        end else begin
            pc <= pc_nxt;
            cs <= (state_nxt != FETCH);
            oe <= (state_nxt != FETCH);
            if (reload) begin
                addr    <= pc_nxt;
                lat_cnt <= LAT_LOAD;
            end else if (state == FETCH && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

    // Queue next-state: pop shifts toward the head, push lands behind what remains
    always_comb begin
        fifo_word_nxt = fifo_word;
        fifo_pc_nxt   = fifo_pc;
        count_nxt     = count;
        if (flush) begin
            count_nxt = 2'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    fifo_word_nxt[i] = fifo_word[i + 1];
                    fifo_pc_nxt[i]   = fifo_pc[i + 1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && i == int'(wr_idx)) begin
                    fifo_word_nxt[i] = bus.Data;
                    fifo_pc_nxt[i]   = pc;
                end
            end
            count_nxt = count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue storage and occupancy
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word[i] <= 32'd0;
                fifo_pc[i]   <= 32'd0;
            end
        end else begin
            count     <= count_nxt;
            fifo_word <= fifo_word_nxt;
            fifo_pc   <= fifo_pc_nxt;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: three instances (default, wrapping
// RESET_PC, single-cycle latency) against a small combinational memory.
module tb_instruction_fetch;
`ifdef IF_PREFETCH_EN
    localparam int GAP2 = 2;   // word spacing, latency 2
    localparam int GAP1 = 1;   // word spacing, latency 1
    localparam int DRAIN = 1;  // cycles from releasing ready to second entry
`else
    localparam int GAP2 = 3;
    localparam int GAP1 = 2;
    localparam int DRAIN = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
    logic        br_a = 1'b0;
    logic [31:0] tgt_a = 32'd0;
    logic [31:0] zero32 = 32'd0;
    logic        zero1 = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_fetch_if ifa ();
    instruction_fetch_if ifb ();
    instruction_fetch_if ifc ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: mem_word = 32'h11;
            32'h4: mem_word = 32'h22;
            32'h8: mem_word = 32'h33;
            32'hC: mem_word = 32'h44;
            default: mem_word = a ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign ifa.Data = (!ifa.CS && !ifa.OE) ? mem_word(ifa.Address) : 32'hBAD0_BAD0;
    assign ifb.Data = (!ifb.CS && !ifb.OE) ? mem_word(ifb.Address) : 32'hBAD0_BAD0;
    assign ifc.Data = (!ifc.CS && !ifc.OE) ? mem_word(ifc.Address) : 32'hBAD0_BAD0;
    assign ifa.instrReady = ready_a;
    assign ifb.instrReady = ready_b;
    assign ifc.instrReady = ready_c;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(2)) dut_a (
        .clock(clk), .reset_n(reset_n), .start(start_a),
        .branchTaken(br_a), .branchTarget(tgt_a), .bus(ifa.master));

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .MEM_LATENCY(2)) dut_b (
        .clock(clk), .reset_n(reset_n), .start(start_b),
        .branchTaken(zero1), .branchTarget(zero32), .bus(ifb.master));

    instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) dut_c (
        .clock(clk), .reset_n(reset_n), .start(start_c),
        .branchTaken(zero1), .branchTarget(zero32), .bus(ifc.master));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        br_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int          cyc, n, wait_n;
    int          vc [4];
    logic [31:0] vpc [4];
    logic [31:0] vw [4];
    logic        seen8;
    logic [31:0] exp_pc [4];
    logic [31:0] exp_w [4];

    initial begin
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;

        // ---- reset state ----
        do_reset();
        check_val("rst_cs", {31'd0, ifa.CS}, 32'd1);
        check_val("rst_oe", {31'd0, ifa.OE}, 32'd1);
        check_val("rst_we", {31'd0, ifa.WE}, 32'd1);
        check_val("rst_valid", {31'd0, ifa.instrValid}, 32'd0);
        check_val("rst_addr", ifa.Address, 32'd0);
        check_val("rst_instr", ifa.instr, 32'd0);
        check_val("rst_instrpc", ifa.instrPC, 32'd0);

        // ---- streaming fetch with ready held high ----
        for (int i = 0; i < 4; i++) begin vc[i] = -1; vpc[i] = '1; vw[i] = '1; end
        start_a = 1'b1; ready_a = 1'b1;
        cyc = 0; n = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (cyc == 1) begin
                check_val("s_addr_c1", ifa.Address, 32'd0);
                check_val("s_cs_c1", {31'd0, ifa.CS}, 32'd0);
                check_val("s_oe_c1", {31'd0, ifa.OE}, 32'd0);
            end
            if (ifa.instrValid) begin
                vc[n] = cyc; vpc[n] = ifa.instrPC; vw[n] = ifa.instr; n++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("s_cyc%0d", i), vc[i], 32'(3 + i * GAP2));
            check_val($sformatf("s_pc%0d", i), vpc[i], exp_pc[i]);
            check_val($sformatf("s_w%0d", i), vw[i], exp_w[i]);
        end
        check_val("s_we", {31'd0, ifa.WE}, 32'd1);

        // ---- back-pressure: ready low for 10 cycles, then drain ----
        do_reset();
        start_a = 1'b1; ready_a = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check_val("bp_cs", {31'd0, ifa.CS}, 32'd1);
        check_val("bp_oe", {31'd0, ifa.OE}, 32'd1);
        check_val("bp_valid", {31'd0, ifa.instrValid}, 32'd1);
        check_val("bp_pc0", ifa.instrPC, 32'h0);
        check_val("bp_w0", ifa.instr, 32'h11);
        ready_a = 1'b1;
        wait_n = 0;
        do begin
            @(negedge clk); wait_n++;
        end while (!(ifa.instrValid && ifa.instrPC != 32'h0) && wait_n < 12);
        check_val("bp_drain_wait", wait_n, DRAIN);
        check_val("bp_pc1", ifa.instrPC, 32'h4);
        check_val("bp_w1", ifa.instr, 32'h22);

        // ---- branch on the capture edge of address 8 ----
        do_reset();
        start_a = 1'b1; ready_a = 1'b1;
        seen8 = 1'b0;
        wait_n = 0;
        do begin
            @(negedge clk); wait_n++;
        end while (!(ifa.Address == 32'h8 && !ifa.CS) && wait_n < 30);
        check_val("br_reach8", {31'd0, (ifa.Address == 32'h8 && !ifa.CS)}, 32'd1);
        @(negedge clk);                     // counter now 0: this edge would capture
        br_a = 1'b1; tgt_a = 32'h0000_0102;
        @(negedge clk);
        br_a = 1'b0;
        check_val("br_valid_b1", {31'd0, ifa.instrValid}, 32'd0);
        check_val("br_addr_b1", ifa.Address, 32'h100);
        check_val("br_cs_b1", {31'd0, ifa.CS}, 32'd0);
        wait_n = 0;
        while (!ifa.instrValid && wait_n < 12) begin
            @(negedge clk); wait_n++;
            if (ifa.instrValid && ifa.instrPC == 32'h8) seen8 = 1'b1;
        end
        check_val("br_lat", wait_n, 2);
        check_val("br_no8", {31'd0, seen8}, 32'd0);
        check_val("br_pc", ifa.instrPC, 32'h100);
        check_val("br_w", ifa.instr, mem_word(32'h100));

        // ---- PC wrap from FFFF_FFF8 ----
        do_reset();
        for (int i = 0; i < 4; i++) begin vpc[i] = '1; vw[i] = '1; end
        start_b = 1'b1; ready_b = 1'b1;
        cyc = 0; n = 0;
        while (n < 3 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (ifb.instrValid) begin vpc[n] = ifb.instrPC; vw[n] = ifb.instr; n++; end
        end
        check_val("wr_pc0", vpc[0], 32'hFFFF_FFF8);
        check_val("wr_pc1", vpc[1], 32'hFFFF_FFFC);
        check_val("wr_pc2", vpc[2], 32'h0000_0000);
        check_val("wr_w2", vw[2], 32'h11);

        // ---- reset mid-read, restart only after start ----
        wait_n = 0;
        while (ifb.CS && wait_n < 10) begin @(negedge clk); wait_n++; end
        check_val("mr_infetch", {31'd0, ifb.CS}, 32'd0);
        reset_n = 1'b0; start_b = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_val("mr_cs", {31'd0, ifb.CS}, 32'd1);
        check_val("mr_oe", {31'd0, ifb.OE}, 32'd1);
        check_val("mr_valid", {31'd0, ifb.instrValid}, 32'd0);
        check_val("mr_addr", ifb.Address, 32'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_val("mr_idle_cs", {31'd0, ifb.CS}, 32'd1);
        check_val("mr_idle_valid", {31'd0, ifb.instrValid}, 32'd0);
        start_b = 1'b1;
        @(negedge clk);
        check_val("mr_restart_addr", ifb.Address, 32'hFFFF_FFF8);
        check_val("mr_restart_cs", {31'd0, ifb.CS}, 32'd0);
        check_val("mr_we", {31'd0, ifb.WE}, 32'd1);

        // ---- single-cycle latency ----
        do_reset();
        for (int i = 0; i < 4; i++) begin vc[i] = -1; vpc[i] = '1; vw[i] = '1; end
        start_c = 1'b1; ready_c = 1'b1;
        cyc = 0; n = 0;
        while (n < 2 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (cyc == 1) check_val("l1_addr_c1", ifc.Address, 32'd0);
            if (ifc.instrValid) begin
                vc[n] = cyc; vpc[n] = ifc.instrPC; vw[n] = ifc.instr; n++;
            end
        end
        check_val("l1_cyc0", vc[0], 32'd2);
        check_val("l1_w0", vw[0], 32'h11);
        check_val("l1_cyc1", vc[1], 32'(2 + GAP1));
        check_val("l1_pc1", vpc[1], 32'h4);
        check_val("l1_w1", vw[1], 32'h22);
        check_val("l1_we", {31'd0, ifc.WE}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the read-side client of the instruction memory that the bios loader fills. After the loader signals completion, the unit walks the program counter through memory and drives chip-select and output-enable with a fixed read latency. It captures each returned word with its address and hands it to decode over a valid/ready handshake. A taken branch from downstream redirects fetch and discards everything already fetched.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after `start`; bits [1:0] are ignored (treated as 00).
- `MEM_LATENCY`, default 2: number of cycles the address and strobes are held before `Data` is sampled; legal range 1..15.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: loader-done level; sampled only in IDLE.
- `branchTaken` in 1: one-cycle redirect request.
- `branchTarget` in 32: redirect address; bits [1:0] are forced to 00.
- `Address` out 32: memory address.
- `Data` in 32: memory read data.
- `CS` out 1: memory chip select, active-low.
- `OE` out 1: memory output enable, active-low.
- `WE` out 1: memory write enable, active-low; tied high (this unit never writes).
- `instr` out 32: fetched instruction word.
- `instrPC` out 32: address `instr` was read from.
- `instrValid` out 1: `instr`/`instrPC` hold a valid entry.
- `instrReady` in 1: decode accepts the entry.

## Operation
- Reset values:
  - state = IDLE, `pc` = `RESET_PC`, `Address` = 0.
  - `CS` = `OE` = `WE` = 1.
  - buffer count = 0; `instrValid` = 0; `instr` = `instrPC` = 0.
- Buffer: FIFO of {word, pc}. Depth is set by the configuration macro. `instrValid` = (count != 0). A pop occurs when `instrValid & instrReady`.
- **IDLE**: strobes high. `start` = 1 → FETCH, `pc` ← `RESET_PC`.
- **FETCH**:
  - `CS` = `OE` = 0, `Address` = `pc`.
  - On entry, the latency counter is loaded with `MEM_LATENCY`-1 and decrements each cycle.
  - On the edge where the counter is 0 (capture), `Data` is pushed with `pc`, and `pc` ← `pc` + 4 (mod 2^32, wraps FFFF_FFFC → 0).
  - Next state after capture: FETCH (counter reloaded) if (count after push and pop) < DEPTH, else STALL.
- **STALL**: strobes high, `Address` holds. → FETCH when (count − pop) < DEPTH.
- **Flush**: `branchTaken` = 1 in FETCH or STALL, at the edge:
  - buffer is emptied;
  - `pc` ← `branchTarget` & ~3;
  - any in-flight read is abandoned and not pushed, even on its capture edge;
  - next state is FETCH with the counter reloaded.
  - `branchTaken` in IDLE is ignored.
- Priorities:
  - reset > flush > capture/pop.
  - A pop in the same cycle as a flush counts as consumed.
  - A capture and a pop in the same cycle leave count unchanged; the FIFO order is preserved.
- Only one read is ever outstanding. An issue is allowed only when count < DEPTH, so a capture never finds the buffer full.
- `start` is ignored once the state has left IDLE. Only `reset_n` returns the unit to IDLE.

## Timing
- `start` sampled at edge E0 → FETCH from cycle 1 with `Address` = `RESET_PC` → capture at edge E(`MEM_LATENCY`) → `instrValid` = 1 from cycle `MEM_LATENCY`+1.
- Strobes change only on clock edges; no combinational path from `Data` to any output.
- Flush at edge Eb → `instrValid` = 0 from cycle b+1. `Address` = target in cycle b+1, first redirected word valid in cycle b+1+`MEM_LATENCY`.
- `reset_n` = 0 mid-read: at that edge, strobes go high and buffer contents are lost.

## Configuration
- `IF_PREFETCH_EN` defined: DEPTH = 2. The next fetch overlaps with the held entry; with `instrReady` held at 1, sustained throughput is one word per `MEM_LATENCY` cycles.
- `IF_PREFETCH_EN` undefined: DEPTH = 1. Fetch issues only once the single entry is popped; with `instrReady` held at 1, throughput is one word per `MEM_LATENCY`+1 cycles.

## Test plan
- Reset and start, `MEM_LATENCY` = 2, memory[0..3] = 11, 22, 33, 44, `instrReady` = 1 → `instrPC`/`instr` = 0/11, 4/22, 8/33, C/44; first valid in cycle 3; spacing 2 cycles with the macro, 3 cycles without.
- `instrReady` = 0 for 10 cycles → with the macro, two entries captured, then STALL with `CS` = 1 and `instrValid` = 1 stable. Raising `instrReady` drains 0/11 then 4/22 in order.
- `branchTaken` with `branchTarget` = 32'h0000_0102 on the capture edge of address 8 → word at 8 is never presented, buffer empty next cycle, `Address` = 32'h100, next valid `instrPC` = 32'h100.
- `RESET_PC` = 32'hFFFF_FFF8 → `instrPC` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `reset_n` = 0 for one cycle during a FETCH → next cycle IDLE, `CS` = `OE` = 1, `instrValid` = 0. Fetch restarts at `RESET_PC` only after `start`.
- `MEM_LATENCY` = 1 → `Data` is sampled on the edge after the address appears; `WE` = 1 throughout every test.
